cnt_mon: RTL and testbench

- Receive-side monitor for the 16-bit free-running counter stream (0,1,…,WRAP_MAX,0,…) produced by the team's counter blocks.
- Samples the stream, acquires lock after LOCK_CNT consecutive correct steps, then flags sequence errors and counts wraps.
- Sits on the far end of a counter link, or alongside it in the testbench, as a self-check.

---
 rtl/cnt_pkg.sv | 27 ++
 rtl/cnt_sat16.sv | 35 +++
 rtl/cnt_mon.sv | 130 +++++++++++++
 tb/tb_cnt_mon.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt_pkg
// Purpose  : Shared counter-stream definitions: width, wrap point, monitor
//            state codes and the successor function.
// Revision : 1.0  initial release
// ============================================================================
package cnt_pkg;

    localparam int CNT_W         = 16;
    localparam int WRAP_MAX_DFLT = 300;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        ERROR   = 2'd3
    } cnt_mon_state_t;

    // Successor of a stream value; anything at or above the wrap point wraps to 0.
    function automatic logic [CNT_W-1:0] exp_next(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] wmax);
        return (v >= wmax) ? '0 : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_sat16.sv
`default_nettype none
// ============================================================================
// Module   : cnt_sat16
// Purpose  : 16-bit event counter with synchronous clear (clear wins, then
//            increment) and optional saturation at 0xFFFF.
// Revision : 1.0  initial release
// ============================================================================
module cnt_sat16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    input  logic        clr,
    input  logic        sat_en,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_hold;

    assign w_hold = sat_en && (r_q == 16'hFFFF);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= {15'd0, inc};
        end else if (inc && !w_hold) begin
            r_q <= r_q + 16'd1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/cnt_mon.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mon
// Purpose  : Receive-side monitor for the free-running counter stream: locks
//            on LOCK_CNT correct steps, then flags errors and counts wraps.
//            Build option CNT_MON_STICKY_ERR_EN makes errors sticky (ERROR
//            state, left only via err_clr or reset).
// Revision : 1.0  initial release
// ============================================================================
module cnt_mon
    import cnt_pkg::*;
#(
    parameter int WRAP_MAX = WRAP_MAX_DFLT,
    parameter int LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [15:0] in_cnt,
    input  logic        err_clr,
    output logic        locked,
    output logic [1:0]  state,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [15:0] wrap_cnt,
    output logic [15:0] exp_cnt
);

    localparam logic [CNT_W-1:0] c_wrap_max = WRAP_MAX[CNT_W-1:0];
    localparam logic [7:0]       c_lock     = LOCK_CNT[7:0];

    cnt_mon_state_t   r_state, w_state_nxt;
    logic [7:0]       r_run, w_run_nxt, w_run_inc;
    logic [CNT_W-1:0] r_exp, w_exp_nxt, w_seed;
    logic             r_locked, r_pulse;
    logic             w_match, w_err_inc, w_wrap_inc;

    assign w_seed    = exp_next(in_cnt, c_wrap_max);
    assign w_match   = (in_cnt == r_exp) && (in_cnt <= c_wrap_max);
    assign w_run_inc = r_run + 8'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_exp    <= '0;
            r_locked <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_exp    <= w_exp_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_pulse  <= w_err_inc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_exp_nxt   = r_exp;
        w_err_inc   = 1'b0;
        w_wrap_inc  = 1'b0;
        if (r_state == ERROR) begin
`ifdef CNT_MON_STICKY_ERR_EN
            if (err_clr) begin
                w_state_nxt = IDLE;
            end
`endif
        end else if (in_valid) begin
            w_exp_nxt = w_seed;
            case (r_state)
                IDLE: begin
                    w_run_nxt   = '0;
                    w_state_nxt = (c_lock == 8'd1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    if (w_match && (w_run_inc == c_lock)) begin
                        w_run_nxt   = '0;
                        w_state_nxt = LOCKED;
                    end else if (w_match) begin
                        w_run_nxt = w_run_inc;
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_wrap_inc = (r_exp == '0);
                    end else begin
                        w_err_inc = 1'b1;
`ifdef CNT_MON_STICKY_ERR_EN
                        w_exp_nxt   = r_exp;
                        w_state_nxt = ERROR;
`else
                        w_run_nxt   = '0;
                        w_state_nxt = ACQUIRE;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    cnt_sat16 u_err_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (w_err_inc),
        .clr    (err_clr),
        .sat_en (1'b1),
        .q      (err_cnt)
    );

    cnt_sat16 u_wrap_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (w_wrap_inc),
        .clr    (err_clr),
        .sat_en (1'b0),
        .q      (wrap_cnt)
    );

    assign locked    = r_locked;
    assign state     = r_state;
    assign err_pulse = r_pulse;
    assign exp_cnt   = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_cnt_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_mon
// Purpose  : Self-checking bench for cnt_mon with a reference model feeding
//            an expected-output queue, plus directed checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnt_mon;
    import cnt_pkg::*;

    localparam int WRAP = 300;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_cnt = '0;
    logic        err_clr = 1'b0;
    logic        locked, err_pulse;
    logic [1:0]  state;
    logic [15:0] err_cnt, wrap_cnt, exp_cnt;

    logic        s_inc = 1'b0;
    logic        s_clr = 1'b0;
    logic [15:0] s_q;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        pl;
        logic [15:0] ec;
        logic [15:0] wc;
        logic [15:0] ex;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_state;
    int          m_run;
    logic [15:0] m_exp, m_err, m_wrap;
    logic        m_pulse;

    cnt_mon #(.WRAP_MAX(WRAP), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_cnt(in_cnt),
        .err_clr(err_clr), .locked(locked), .state(state), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .exp_cnt(exp_cnt)
    );

    cnt_sat16 u_sat (
        .clk(clk), .rstn(rstn), .inc(s_inc), .clr(s_clr), .sat_en(1'b1), .q(s_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_run = 0; m_exp = '0; m_err = '0; m_wrap = '0; m_pulse = 1'b0;
    endtask

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model_step(input logic v, input logic [15:0] c, input logic clr);
        logic [15:0] nx;
        logic        mt, einc, winc;
        nx   = (c >= 16'(WRAP)) ? 16'd0 : c + 16'd1;
        mt   = (c == m_exp);
        einc = 1'b0;
        winc = 1'b0;
        if (m_state == 2'd3) begin
            if (clr) m_state = 2'd0;
        end else if (v) begin
            if (m_state == 2'd0) begin
                m_exp = nx; m_run = 0;
                m_state = (LOCK == 1) ? 2'd2 : 2'd1;
            end else if (m_state == 2'd1) begin
                m_exp = nx;
                if (mt) begin
                    m_run++;
                    if (m_run == LOCK) begin m_state = 2'd2; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (mt && c <= 16'(WRAP)) begin
                    m_exp = nx;
                    winc  = (c == 16'd0);
                end else begin
                    einc = 1'b1;
`ifdef CNT_MON_STICKY_ERR_EN
                    m_state = 2'd3;
`else
                    m_state = 2'd1; m_run = 0; m_exp = nx;
`endif
                end
            end
        end
        if (clr) begin m_err = '0; m_wrap = '0; end
        if (einc && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        if (winc) m_wrap = m_wrap + 16'd1;
        m_pulse = einc;
        sb.push_back('{st: m_state, lk: (m_state == 2'd2), pl: m_pulse,
                       ec: m_err, wc: m_wrap, ex: m_exp});
    endtask

    task automatic step(input logic v, input logic [15:0] c, input logic clr);
        exp_t e;
        in_valid = v; in_cnt = c; err_clr = clr;
        model_step(v, c, clr);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", 16'(state), 16'(e.st));
        chk("locked", 16'(locked), 16'(e.lk));
        chk("err_pulse", 16'(err_pulse), 16'(e.pl));
        chk("err_cnt", err_cnt, e.ec);
        chk("wrap_cnt", wrap_cnt, e.wc);
        chk("exp_cnt", exp_cnt, e.ex);
    endtask

    task automatic lock_seq(input int start);
        for (int i = 0; i < LOCK + 1; i++) step(1'b1, 16'(start + i), 1'b0);
        chk("lock_seq_locked", 16'(locked), 16'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 16'(state), 16'd0);
        chk({tag, "_locked"}, 16'(locked), 16'd0);
        chk({tag, "_pulse"}, 16'(err_pulse), 16'd0);
        chk({tag, "_err"}, err_cnt, 16'd0);
        chk({tag, "_wrap"}, wrap_cnt, 16'd0);
        chk({tag, "_exp"}, exp_cnt, 16'd0);
    endtask

    initial begin
        model_reset();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Clean stream with a three-cycle valid gap between 20 and 21.
        for (int i = 0; i <= WRAP; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 3) chk("pre_lock", 16'(locked), 16'd0);
            if (i == 4) chk("lock_after_4", 16'(locked), 16'd1);
            if (i == 20) begin
                for (int g = 0; g < 3; g++) step(1'b0, 16'h1234, 1'b0);
            end
        end
        step(1'b1, 16'd0, 1'b0);
        chk("first_wrap", wrap_cnt, 16'd1);
        chk("clean_err", err_cnt, 16'd0);
        step(1'b1, 16'd1, 1'b0);

        // Glitch while locked.
        for (int i = 2; i <= 11; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'd50, 1'b0);
        chk("glitch_pulse", 16'(err_pulse), 16'd1);
        chk("glitch_err", err_cnt, 16'd1);
`ifdef CNT_MON_STICKY_ERR_EN
        chk("glitch_state", 16'(state), 16'd3);
        step(1'b1, 16'd51, 1'b0);
        step(1'b1, 16'd52, 1'b0);
        chk("sticky_err_frozen", err_cnt, 16'd1);
        chk("sticky_exp_frozen", exp_cnt, 16'd12);
        step(1'b1, 16'd53, 1'b1);
        chk("sticky_clr_state", 16'(state), 16'd0);
        chk("sticky_clr_err", err_cnt, 16'd0);
        lock_seq(54);
`else
        chk("glitch_state", 16'(state), 16'd1);
        for (int i = 51; i <= 54; i++) step(1'b1, 16'(i), 1'b0);
        chk("relock", 16'(locked), 16'd1);
        step(1'b1, 16'd55, 1'b0);
`endif

        // Out-of-range value while locked.
        step(1'b1, 16'd400, 1'b0);
        chk("oor_pulse", 16'(err_pulse), 16'd1);
`ifdef CNT_MON_STICKY_ERR_EN
        chk("oor_exp", exp_cnt, 16'd59);
        step(1'b0, 16'd0, 1'b1);
`else
        chk("oor_exp", exp_cnt, 16'd0);
        chk("oor_err", err_cnt, 16'd2);
`endif
        step(1'b0, 16'd0, 1'b0);
        chk("pulse_one_cycle", 16'(err_pulse), 16'd0);

        // Clear coinciding with an error increment.
        lock_seq(0);
        step(1'b1, 16'd99, 1'b1);
        chk("clr_with_err", err_cnt, 16'd1);
        step(1'b0, 16'd0, 1'b1);

        // Clear coinciding with a wrap increment.
        lock_seq(295);
        step(1'b1, 16'd300, 1'b0);
        step(1'b1, 16'd0, 1'b1);
        chk("clr_with_wrap", wrap_cnt, 16'd1);
        chk("clr_with_wrap_err", err_cnt, 16'd0);

        // Two more wraps, then asynchronous reset between edges.
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i <= WRAP; i++) step(1'b1, 16'(i), 1'b0);
            step(1'b1, 16'd0, 1'b0);
        end
        chk("wrap3", wrap_cnt, 16'd3);
        chk("wrap3_locked", 16'(locked), 16'd1);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rstn = 1'b1;
        lock_seq(7);
        step(1'b1, 16'd12, 1'b0);

        // Saturation of the error counter primitive.
        in_valid = 1'b0;
        s_inc = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", s_q, 16'hFFFE);
        @(posedge clk); #1;
        chk("sat_ffff", s_q, 16'hFFFF);
        @(posedge clk); #1;
        chk("sat_hold", s_q, 16'hFFFF);
        s_clr = 1'b1;
        @(posedge clk); #1;
        chk("sat_clr_inc", s_q, 16'd1);
        s_clr = 1'b0; s_inc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
